mm_timing_loop: RTL and testbench
=================================

// Module: mm_timing_loop
// PURPOSE
//   Mueller-Muller timing-error detector plus PI loop filter for the PAM4 CDR.
//   Sits directly downstream of the PAM4 slicer. Consumes each sampled value x_n
//   and its decoded level (-3/-1/+1/+3), and forms the timing error
//   e = x[n-1]*d[n] - x[n]*d[n-1]. It filters e into a wrapping phase code for
//   the sampling-phase rotator, with up/dn pulses and a lock indicator.
// PARAMETERS
//   KP_SHIFT       4    proportional gain = 2^-KP_SHIFT (arithmetic right shift)
//   KI_SHIFT       8    integral gain = 2^-KI_SHIFT applied to integrator output
//   ACC_W          16   width of integrator and phase accumulator (>=12)
//   PHASE_W        7    width of phase_code (<= ACC_W)
//   LOCK_THRESH    8    |e| < LOCK_THRESH counts as a quiet update
//   UNLOCK_THRESH  32   |e| >= UNLOCK_THRESH while locked drops lock
//   LOCK_CNT       64   consecutive quiet updates required to declare lock
// PORTS
//   clk        in   1        rising-edge clock
//   rst        in   1        synchronous, active-high reset
//   in_valid   in   1        x_n/decoded valid this cycle
//   x_n        in   8        signed sampled input
//   decoded    in   4        signed slicer level, only -3/-1/+1/+3 legal
//   ted_valid  out  1        one-cycle strobe: ted_err updated
//   ted_err    out  12       signed timing error e
//   phase_code out  PHASE_W  phase_acc[ACC_W-1 -: PHASE_W]
//   up         out  1        one-cycle pulse: ctrl > 0 on this update
//   dn         out  1        one-cycle pulse: ctrl < 0 on this update
//   locked     out  1        loop locked (level)
// BEHAVIOUR
//   Reset: all outputs 0. Integrator, phase_acc, lock counter, x_prev and d_prev are 0.
//     FSM enters IDLE. Reset wins over in_valid in the same cycle.
//   FSM states: IDLE, TRACK, LOCK.
//   - IDLE: in_valid captures x_prev/d_prev, goes to TRACK, produces no ted_valid.
//   - TRACK -> LOCK: lock counter reaches LOCK_CNT.
//     An update with |e| >= LOCK_THRESH clears the counter.
//   - LOCK -> TRACK: an update with |e| >= UNLOCK_THRESH. This clears the counter.
//     Updates with LOCK_THRESH <= |e| < UNLOCK_THRESH keep LOCK and hold the counter.
//   TED (TRACK/LOCK): on in_valid, compute e in 12-bit signed (range +-768, no overflow).
//     Register it to ted_err, pulse ted_valid the next cycle, load x_prev/d_prev with
//     the current inputs.
//   in_valid low: full hold. Pairing spans gaps; non-consecutive valid samples
//     are still treated as adjacent symbols.
//   Loop filter: evaluated in the cycle ted_valid=1, results registered (t+2).
//   - integ_n = sat(integ + sext(e)), clamped to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
//     Never wraps.
//   - ctrl = (sext(e) >>> KP_SHIFT) + (integ_n >>> KI_SHIFT), ACC_W signed.
//   - phase_acc += ctrl, modulo 2^ACC_W. Wrap is intentional: the rotator is circular.
//   - up = (ctrl > 0), dn = (ctrl < 0), both for exactly one cycle. Both are 0 if ctrl == 0.
//   locked = (state == LOCK), registered. It changes in the same cycle as the
//     phase_code update.
//   Latency: in_valid at t -> ted_valid/ted_err at t+1 -> phase_code/up/dn/locked at t+2.
//     Back-to-back in_valid is accepted every cycle. No backpressure.
//   Illegal decoded values (even or |d| > 3) are used arithmetically as given.
//     No error flag is raised.
// TESTING
//   1 rst, then in_valid x=50,d=+1 -> no ted_valid, state TRACK, all outputs 0.
//   2 then x=100,d=+3 -> t+1: ted_valid=1, ted_err=50.
//     t+2: integ=50, ctrl=3, phase_acc=3, up=1, dn=0.
//   3 ACC_W=12, repeat prev(-65,-3)/cur(127,+3) pairs (e=186 alternating sign handled)
//     -> integ clamps at 2047, never wraps negative.
//   4 preload phase_acc near 2^ACC_W-1, positive ctrl -> phase_acc wraps to small value.
//     phase_code rolls from max to 0.
//   5 LOCK_CNT+1 samples x=32,d=+1 (e=0) -> locked=1 at t+2 of 64th update.
//     Then one pair with e=186 -> locked=0 at its t+2.
//   6 rst asserted mid-stream with in_valid=1 -> next cycle all outputs 0, state IDLE.
//     in_valid gaps of 3 cycles give the same ted_err as gapless.

Source files
------------

// File: rtl/mm_timing_loop_if.sv
// ---------------------------------------------------------------------------
// mm_timing_loop_if
//   Bundle between the PAM4 slicer side and the Mueller-Muller timing loop.
//   Handshake: in_valid marks a sample that is consumed in that same cycle.
//   There is no ready and no backpressure, so every sample presented with
//   in_valid=1 is accepted. ted_valid, up and dn are single-cycle strobes.
//   The remaining outputs are levels.
//
//   Signals:
//     in_valid   : x_n/decoded valid this cycle
//     x_n        : signed sampled value (8 bit)
//     decoded    : signed slicer level (4 bit, nominally -3/-1/+1/+3)
//     ted_valid  : ted_err updated this cycle
//     ted_err    : signed timing error (12 bit)
//     phase_code : top PHASE_W bits of the phase accumulator
//     up / dn    : direction pulses of the loop-filter output
//     locked     : loop lock indicator
//
//   Modports: master = sample producer, slave = timing loop.
// ---------------------------------------------------------------------------
interface mm_timing_loop_if #(
    parameter int PHASE_W = 7
);
    logic                     in_valid;
    logic signed [7:0]        x_n;
    logic signed [3:0]        decoded;
    logic                     ted_valid;
    logic signed [11:0]       ted_err;
    logic [PHASE_W-1:0]       phase_code;
    logic                     up;
    logic                     dn;
    logic                     locked;

    modport master (
        output in_valid, x_n, decoded,
        input  ted_valid, ted_err, phase_code, up, dn, locked
    );

    modport slave (
        input  in_valid, x_n, decoded,
        output ted_valid, ted_err, phase_code, up, dn, locked
    );
endinterface

// File: rtl/mm_timing_loop.sv
// ---------------------------------------------------------------------------
// mm_timing_loop
//   Mueller-Muller timing-error detector followed by a PI loop filter for the
//   PAM4 CDR. It forms e = x[n-1]*d[n] - x[n]*d[n-1] from consecutive valid
//   samples, integrates e with saturation, and accumulates the PI output into
//   a wrapping phase accumulator that drives the sampling-phase rotator.
//
//   Ports:
//     clk       : rising-edge clock
//     rst       : synchronous active-high reset
//     bus       : mm_timing_loop_if.slave (samples in, error/phase/lock out)
//     fsm_state : current loop state (IDLE=0, TRACK=1, LOCK=2), for debug
//
//   Timing: in_valid at t -> ted_valid/ted_err at t+1 ->
//           phase_code/up/dn/locked at t+2.
// ---------------------------------------------------------------------------
module mm_timing_loop #(
    parameter int KP_SHIFT      = 4,
    parameter int KI_SHIFT      = 8,
    parameter int ACC_W         = 16,
    parameter int PHASE_W       = 7,
    parameter int LOCK_THRESH   = 8,
    parameter int UNLOCK_THRESH = 32,
    parameter int LOCK_CNT      = 64
) (
    input  logic             clk,
    input  logic             rst,
    mm_timing_loop_if.slave  bus,
    output logic [1:0]       fsm_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        LOCK  = 2'd2
    } state_t;

    localparam int CNT_W = $clog2(LOCK_CNT + 1);

    // Saturation bounds of the integrator, expressed one bit wider than the
    // integrator so the unclamped sum can be compared directly.
    localparam logic signed [ACC_W:0] SUM_MAX = {2'b00, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] SUM_MIN = {2'b11, {(ACC_W-1){1'b0}}};

    state_t                    state;
    state_t                    state_next;
    logic [CNT_W-1:0]          lock_cnt;
    logic [CNT_W-1:0]          cnt_next;
    logic [CNT_W-1:0]          cnt_inc;

    logic signed [7:0]         x_prev;
    logic signed [3:0]         d_prev;
    logic                      ted_valid_r;
    logic signed [11:0]        ted_err_r;
    logic signed [11:0]        e_calc;
    logic [11:0]               abs_e;

    logic signed [ACC_W-1:0]   integ;
    logic signed [ACC_W-1:0]   integ_n;
    logic signed [ACC_W:0]     integ_sum;
    logic signed [ACC_W-1:0]   e_ext;
    logic signed [ACC_W-1:0]   ctrl;
    logic [ACC_W-1:0]          phase_acc;
    logic                      up_r;
    logic                      dn_r;
    logic                      locked_r;

    // Timing error from the previous accepted sample and the current one.
    // 12 bits hold the legal range (+-768); illegal levels simply wrap.
    always_comb begin
        e_calc = (12'(x_prev) * 12'(bus.decoded)) - (12'(bus.x_n) * 12'(d_prev));
    end

    // Loop filter, evaluated on the registered error.
    always_comb begin
        e_ext     = ACC_W'(ted_err_r);
        integ_sum = (ACC_W+1)'(integ) + (ACC_W+1)'(e_ext);
        if (integ_sum > SUM_MAX) begin
            integ_n = ACC_W'(SUM_MAX);
        end else if (integ_sum < SUM_MIN) begin
            integ_n = ACC_W'(SUM_MIN);
        end else begin
            integ_n = ACC_W'(integ_sum);
        end
        ctrl  = (e_ext >>> KP_SHIFT) + (integ_n >>> KI_SHIFT);
        abs_e = ted_err_r[11] ? 12'(-ted_err_r) : 12'(ted_err_r);
    end

    // Lock FSM. IDLE leaves on the first sample (which only primes x_prev and
    // d_prev); TRACK/LOCK move only on error updates.
    always_comb begin
        state_next = state;
        cnt_next   = lock_cnt;
        cnt_inc    = lock_cnt + 1'b1;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    state_next = TRACK;
                end
            end
            TRACK: begin
                if (ted_valid_r) begin
                    if (abs_e >= 12'(LOCK_THRESH)) begin
                        cnt_next = '0;
                    end else if (cnt_inc >= CNT_W'(LOCK_CNT)) begin
                        cnt_next   = CNT_W'(LOCK_CNT);
                        state_next = LOCK;
                    end else begin
                        cnt_next = cnt_inc;
                    end
                end
            end
            LOCK: begin
                // Moderate errors keep lock and leave the counter untouched.
                if (ted_valid_r && (abs_e >= 12'(UNLOCK_THRESH))) begin
                    cnt_next   = '0;
                    state_next = TRACK;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            lock_cnt    <= '0;
            x_prev      <= '0;
            d_prev      <= '0;
            ted_valid_r <= 1'b0;
            ted_err_r   <= '0;
            integ       <= '0;
            phase_acc   <= '0;
            up_r        <= 1'b0;
            dn_r        <= 1'b0;
            locked_r    <= 1'b0;
        end else begin
            state       <= state_next;
            lock_cnt    <= cnt_next;
            ted_valid_r <= bus.in_valid && (state != IDLE);
            up_r        <= 1'b0;
            dn_r        <= 1'b0;
            locked_r    <= (state_next == LOCK);

            // Gaps hold everything, so non-adjacent valid samples pair up.
            if (bus.in_valid) begin
                x_prev <= bus.x_n;
                d_prev <= bus.decoded;
                if (state != IDLE) begin
                    ted_err_r <= e_calc;
                end
            end

            if (ted_valid_r) begin
                integ     <= integ_n;
                // Modulo wrap is intended: the rotator phase is circular.
                phase_acc <= phase_acc + ctrl;
                up_r      <= !ctrl[ACC_W-1] && (ctrl != '0);
                dn_r      <= ctrl[ACC_W-1];
            end
        end
    end

    assign bus.ted_valid  = ted_valid_r;
    assign bus.ted_err    = ted_err_r;
    assign bus.phase_code = phase_acc[ACC_W-1 -: PHASE_W];
    assign bus.up         = up_r;
    assign bus.dn         = dn_r;
    assign bus.locked     = locked_r;
    assign fsm_state      = state;

endmodule

// File: tb/tb_mm_timing_loop.sv
// ---------------------------------------------------------------------------
// tb_mm_timing_loop
//   Bench for mm_timing_loop with ACC_W=12 so saturation and phase wrap are
//   reached quickly. A reference model predicts every error update; the
//   monitor pops predictions when ted_valid fires and checks the loop-filter
//   outputs one cycle later.
// ---------------------------------------------------------------------------
module tb_mm_timing_loop;

    localparam int ACC_W   = 12;
    localparam int PHASE_W = 7;
    localparam int KP      = 4;
    localparam int KI      = 8;
    localparam int LT      = 8;
    localparam int UT      = 32;
    localparam int LC      = 64;
    localparam int CODE_SH = ACC_W - PHASE_W;
    localparam int ACC_MAX = (1 << (ACC_W - 1)) - 1;
    localparam int ACC_MIN = -(1 << (ACC_W - 1));
    localparam int ACC_MSK = (1 << ACC_W) - 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mm_timing_loop_if #(.PHASE_W(PHASE_W)) bus ();
    logic [1:0] fsm_state;

    mm_timing_loop #(
        .KP_SHIFT(KP), .KI_SHIFT(KI), .ACC_W(ACC_W), .PHASE_W(PHASE_W),
        .LOCK_THRESH(LT), .UNLOCK_THRESH(UT), .LOCK_CNT(LC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .fsm_state(fsm_state)
    );

    // ---------------- scoreboard ----------------
    typedef struct {
        int err;
        int code;
        bit up;
        bit dn;
        bit lk;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_st, m_cnt, m_xp, m_dp, m_integ, m_phase, m_last_code;
    int m_up_wraps = 0;
    int m_dn_wraps = 0;

    task automatic model_reset();
        m_st = 0; m_cnt = 0; m_xp = 0; m_dp = 0; m_integ = 0; m_phase = 0;
        m_last_code = 0;
    endtask

    task automatic model_sample(input int x, input int d, input bit use_tab, input int tab_err);
        int   e, ctrl, ae;
        exp_t r;
        if (m_st == 0) begin
            m_xp = x; m_dp = d; m_st = 1;
            return;
        end
        e = m_xp * d - x * m_dp;
        m_xp = x; m_dp = d;
        m_integ = m_integ + e;
        if (m_integ > ACC_MAX) m_integ = ACC_MAX;
        if (m_integ < ACC_MIN) m_integ = ACC_MIN;
        ctrl    = (e >>> KP) + (m_integ >>> KI);
        m_phase = (m_phase + ctrl) & ACC_MSK;
        ae = (e < 0) ? -e : e;
        if (m_st == 1) begin
            if (ae >= LT) m_cnt = 0;
            else begin
                m_cnt++;
                if (m_cnt >= LC) m_st = 2;
            end
        end else if (ae >= UT) begin
            m_st = 1; m_cnt = 0;
        end
        r.err  = use_tab ? tab_err : e;
        r.code = m_phase >> CODE_SH;
        r.up   = (ctrl > 0);
        r.dn   = (ctrl < 0);
        r.lk   = (m_st == 2);
        if (m_last_code >= 96 && r.code < 32) m_up_wraps++;
        if (m_last_code < 32 && r.code >= 96) m_dn_wraps++;
        m_last_code = r.code;
        exp_q.push_back(r);
    endtask

    // ---------------- monitor ----------------
    bit   pend = 0;
    exp_t pend_r;
    int   d_last_code = 0;
    int   d_up_wraps  = 0;
    int   d_dn_wraps  = 0;

    always @(negedge clk) begin
        if (pend) begin
            chk("phase_code", int'(bus.phase_code), pend_r.code);
            chk("up", int'(bus.up), int'(pend_r.up));
            chk("dn", int'(bus.dn), int'(pend_r.dn));
            chk("locked", int'(bus.locked), int'(pend_r.lk));
            if (d_last_code >= 96 && int'(bus.phase_code) < 32) d_up_wraps++;
            if (d_last_code < 32 && int'(bus.phase_code) >= 96) d_dn_wraps++;
            d_last_code = int'(bus.phase_code);
            pend = 0;
        end else begin
            chk("updn_idle", int'({bus.up, bus.dn}), 0);
        end
        if (bus.ted_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_ted_valid", 1, 0);
            end else begin
                exp_t r;
                r = exp_q.pop_front();
                chk("ted_err", int'(bus.ted_err), r.err);
                if (!rst) begin
                    pend   = 1;
                    pend_r = r;
                end
            end
        end
        if (rst) begin
            exp_q.delete();
            pend        = 0;
            d_last_code = 0;
        end
    end

    // ---------------- driver tasks ----------------
    // All tasks start and end 1 time unit after a rising edge.
    task automatic do_reset(input int n);
        rst = 1'b1;
        bus.in_valid = 1'b0;
        model_reset();
        repeat (n) begin @(posedge clk); #1; end
        rst = 1'b0;
    endtask

    task automatic drive(input int x, input int d, input int gap, input bit use_tab, input int tab_err);
        bus.in_valid = 1'b1;
        bus.x_n      = 8'(x);
        bus.decoded  = 4'(d);
        model_sample(x, d, use_tab, tab_err);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_ted_valid"}, int'(bus.ted_valid), 0);
        chk({tag, "_ted_err"}, int'(bus.ted_err), 0);
        chk({tag, "_phase_code"}, int'(bus.phase_code), 0);
        chk({tag, "_updn"}, int'({bus.up, bus.dn}), 0);
        chk({tag, "_locked"}, int'(bus.locked), 0);
        chk({tag, "_state"}, int'(fsm_state), 0);
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        int x;
        int d;
        bit has_err;
        int exp_err;
    } vec_t;

    vec_t vecs[9];

    task automatic run_table(input int gap);
        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].x, vecs[i].d, gap, vecs[i].has_err, vecs[i].exp_err);
            if (i == 0) begin
                // First sample only primes the pairing registers.
                chk("first_state", int'(fsm_state), 1);
                chk("first_no_ted", int'(bus.ted_valid), 0);
                chk("first_phase", int'(bus.phase_code), 0);
            end
        end
    endtask

    initial begin
        vecs[0] = '{x:  50, d:  1, has_err: 1'b0, exp_err:    0};
        vecs[1] = '{x: 100, d:  3, has_err: 1'b1, exp_err:   50};
        vecs[2] = '{x: -65, d: -3, has_err: 1'b1, exp_err: -105};
        vecs[3] = '{x: 127, d:  3, has_err: 1'b1, exp_err:  186};
        vecs[4] = '{x: 127, d: -3, has_err: 1'b1, exp_err: -762};
        vecs[5] = '{x:  20, d:  2, has_err: 1'b1, exp_err:  314};
        vecs[6] = '{x:  -7, d: -8, has_err: 1'b1, exp_err: -146};
        vecs[7] = '{x:   0, d:  1, has_err: 1'b1, exp_err:   -7};
        vecs[8] = '{x: -128, d: -3, has_err: 1'b1, exp_err: 128};

        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.x_n      = '0;
        bus.decoded  = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        do_reset(2);
        check_cleared("reset");

        // Directed pattern, back-to-back.
        run_table(0);
        idle(4);

        // Reset asserted together with in_valid: reset wins.
        drive(10, 1, 0, 1'b0, 0);
        drive(20, -1, 0, 1'b0, 0);
        rst = 1'b1;
        bus.in_valid = 1'b1;
        bus.x_n      = 8'd99;
        bus.decoded  = 4'd3;
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        check_cleared("midrst");

        // Same pattern with 3-cycle gaps must give identical errors.
        run_table(3);
        idle(4);

        // Persistently positive error: integrator clamps high, phase wraps up.
        do_reset(2);
        for (int i = 0; i < 40; i++) begin
            drive(127, -3, 0, 1'b0, 0);
            drive(127, 3, 0, 1'b0, 0);
            drive(-128, 3, 0, 1'b0, 0);
        end
        idle(4);

        // Persistently negative error: clamps low, phase wraps down.
        do_reset(2);
        for (int i = 0; i < 40; i++) begin
            drive(-127, -3, 0, 1'b0, 0);
            drive(-127, 3, 0, 1'b0, 0);
            drive(127, 3, 0, 1'b0, 0);
        end
        idle(4);

        // Lock acquisition on e=0, hold on moderate error, drop on large one.
        do_reset(2);
        for (int i = 0; i < LC + 1; i++) drive(32, 1, 0, 1'b0, 0);
        drive(-65, -3, 0, 1'b1, -31);
        drive(127, 3, 0, 1'b1, 186);
        drive(127, 3, 1, 1'b0, 0);
        idle(4);

        // Random legal traffic with random gaps.
        do_reset(2);
        for (int i = 0; i < 80; i++) begin
            int x, d, g;
            x = int'($urandom_range(0, 255)) - 128;
            case ($urandom_range(0, 3))
                0: d = -3;
                1: d = -1;
                2: d = 1;
                default: d = 3;
            endcase
            g = int'($urandom_range(0, 2));
            drive(x, d, g, 1'b0, 0);
        end
        idle(6);

        chk("drain_empty", exp_q.size(), 0);
        chk("up_wraps", d_up_wraps, m_up_wraps);
        chk("dn_wraps", d_dn_wraps, m_dn_wraps);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
